// File: rtl/vga_pkg.sv
// Shared VGA constants: counter width and the default 800x600@60 (40 MHz) timing mode.
package vga_pkg;

   localparam int VGA_CNT_W = 11;
   localparam int VGA_RGB_W = 12;

   localparam int HOR_TOTAL       = 1056;
   localparam int HOR_BLANK_START = 800;
   localparam int HOR_SYNC_START  = 840;
   localparam int HOR_SYNC_TIME   = 128;

   localparam int VER_TOTAL       = 628;
   localparam int VER_BLANK_START = 600;
   localparam int VER_SYNC_START  = 601;
   localparam int VER_SYNC_TIME   = 4;

   typedef logic [VGA_CNT_W-1:0] vga_cnt_t;
   typedef logic [VGA_RGB_W-1:0] vga_rgb_t;

endpackage

// File: rtl/vga_if.sv
// Pixel bus passed between draw-pipeline stages: position, sync, blanking and colour.
interface vga_if;
   import vga_pkg::*;

   vga_cnt_t hcount;
   vga_cnt_t vcount;
   logic     hsync;
   logic     vsync;
   logic     hblnk;
   logic     vblnk;
   vga_rgb_t rgb;

   modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/vga_timing_gen.sv
// Head of the draw pipeline: free-running h/v counters with registered sync/blank flags.
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int   H_TOTAL       = HOR_TOTAL,
   parameter int   H_BLANK_START = HOR_BLANK_START,
   parameter int   H_SYNC_START  = HOR_SYNC_START,
   parameter int   H_SYNC_TIME   = HOR_SYNC_TIME,
   parameter int   V_TOTAL       = VER_TOTAL,
   parameter int   V_BLANK_START = VER_BLANK_START,
   parameter int   V_SYNC_START  = VER_SYNC_START,
   parameter int   V_SYNC_TIME   = VER_SYNC_TIME,
   parameter logic SYNC_POL      = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   vga_if.out          out,
`ifdef VGA_TIMING_FRAME_CNT_EN
   output logic [15:0] frame_cnt,
`endif
   output logic        frame_start
);

   localparam int       CNT_MAX = (1 << VGA_CNT_W) - 1;
   localparam vga_cnt_t H_LAST  = vga_cnt_t'(H_TOTAL - 1);
   localparam vga_cnt_t V_LAST  = vga_cnt_t'(V_TOTAL - 1);

   if (H_TOTAL < 1 || H_TOTAL > CNT_MAX || V_TOTAL < 1 || V_TOTAL > CNT_MAX ||
       H_BLANK_START > CNT_MAX || H_SYNC_START > CNT_MAX || H_SYNC_TIME > CNT_MAX ||
       V_BLANK_START > CNT_MAX || V_SYNC_START > CNT_MAX || V_SYNC_TIME > CNT_MAX)
   begin : g_bad_param
      $error("vga_timing_gen: timing parameters must fit in %0d bits", VGA_CNT_W);
   end

   function automatic logic in_window(input vga_cnt_t cnt, input int start, input int len);
      return (int'(cnt) >= start) && (int'(cnt) < start + len);
   endfunction

   vga_cnt_t h_nxt, v_nxt;
   vga_cnt_t hcount_d, hcount_q;
   vga_cnt_t vcount_d, vcount_q;
   logic     hsync_d, hsync_q;
   logic     vsync_d, vsync_q;
   logic     hblnk_d, hblnk_q;
   logic     vblnk_d, vblnk_q;
   logic     frame_start_d, frame_start_q;

   always_comb begin
      // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
      h_nxt         = (hcount_q == H_LAST) ? '0 : hcount_q + vga_cnt_t'(1);
      v_nxt         = vcount_q;
      hcount_d      = hcount_q;
      vcount_d      = vcount_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      hblnk_d       = hblnk_q;
      vblnk_d       = vblnk_q;
      frame_start_d = 1'b0;

      if (hcount_q == H_LAST) begin
         v_nxt = (vcount_q == V_LAST) ? '0 : vcount_q + vga_cnt_t'(1);
      end

      // Flags decode the next position so they land in the same cycle as the counts.
      if (en) begin
         hcount_d      = h_nxt;
         vcount_d      = v_nxt;
         hblnk_d       = int'(h_nxt) >= H_BLANK_START;
         vblnk_d       = int'(v_nxt) >= V_BLANK_START;
         hsync_d       = in_window(h_nxt, H_SYNC_START, H_SYNC_TIME) ? SYNC_POL : ~SYNC_POL;
         vsync_d       = in_window(v_nxt, V_SYNC_START, V_SYNC_TIME) ? SYNC_POL : ~SYNC_POL;
         frame_start_d = (h_nxt == '0) && (v_nxt == '0);
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcount_q      <= '0;
         vcount_q      <= '0;
         hsync_q       <= ~SYNC_POL;
         vsync_q       <= ~SYNC_POL;
         hblnk_q       <= 1'b0;
         vblnk_q       <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hcount_q      <= hcount_d;
         vcount_q      <= vcount_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         hblnk_q       <= hblnk_d;
         vblnk_q       <= vblnk_d;
         frame_start_q <= frame_start_d;
      end
   end

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0] frame_cnt_d, frame_cnt_q;

   always_comb begin
      frame_cnt_d = frame_start_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) frame_cnt_q <= '0;
      else        frame_cnt_q <= frame_cnt_d;
   end

   assign frame_cnt = frame_cnt_q;
`endif

   assign out.hcount  = hcount_q;
   assign out.vcount  = vcount_q;
   assign out.hsync   = hsync_q;
   assign out.vsync   = vsync_q;
   assign out.hblnk   = hblnk_q;
   assign out.vblnk   = vblnk_q;
   assign out.rgb     = '0;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: default mode (both polarities) over two lines, plus a shrunken mode
// run over whole frames for vertical, frame_start, enable-gating and frame_cnt behaviour.
module tb_vga_timing_gen;
   import vga_pkg::*;

   localparam int S_HT  = 20, S_HBS = 12, S_HSS = 14, S_HST = 3;
   localparam int S_VT  = 10, S_VBS = 7,  S_VSS = 8,  S_VST = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, en_d, en_s;
   logic fs_d, fs_s, fs_p;
   logic [15:0] fc_d, fc_s, fc_p;

   vga_if bus_d ();
   vga_if bus_s ();
   vga_if bus_p ();

   vga_timing_gen dut_d (
      .clk(clk), .rst_n(rst_n), .en(en_d), .out(bus_d),
`ifdef VGA_TIMING_FRAME_CNT_EN
      .frame_cnt(fc_d),
`endif
      .frame_start(fs_d)
   );

   vga_timing_gen #(.SYNC_POL(1'b0)) dut_p (
      .clk(clk), .rst_n(rst_n), .en(en_d), .out(bus_p),
`ifdef VGA_TIMING_FRAME_CNT_EN
      .frame_cnt(fc_p),
`endif
      .frame_start(fs_p)
   );

   vga_timing_gen #(
      .H_TOTAL(S_HT), .H_BLANK_START(S_HBS), .H_SYNC_START(S_HSS), .H_SYNC_TIME(S_HST),
      .V_TOTAL(S_VT), .V_BLANK_START(S_VBS), .V_SYNC_START(S_VSS), .V_SYNC_TIME(S_VST),
      .SYNC_POL(1'b1)
   ) dut_s (
      .clk(clk), .rst_n(rst_n), .en(en_s), .out(bus_s),
`ifdef VGA_TIMING_FRAME_CNT_EN
      .frame_cnt(fc_s),
`endif
      .frame_start(fs_s)
   );

`ifndef VGA_TIMING_FRAME_CNT_EN
   assign fc_d = '0;
   assign fc_s = '0;
   assign fc_p = '0;
`endif

   logic [31:0] obs_d, obs_s, obs_p;
   assign obs_d = {5'b0, bus_d.hcount, bus_d.vcount, bus_d.hsync, bus_d.vsync, bus_d.hblnk, bus_d.vblnk, fs_d};
   assign obs_s = {5'b0, bus_s.hcount, bus_s.vcount, bus_s.hsync, bus_s.vsync, bus_s.hblnk, bus_s.vblnk, fs_s};
   assign obs_p = {5'b0, bus_p.hcount, bus_p.vcount, bus_p.hsync, bus_p.vsync, bus_p.hblnk, bus_p.vblnk, fs_p};

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pack(input int h, v, input logic hs, vs, hb, vb, fs);
      return {5'b0, 11'(h), 11'(v), hs, vs, hb, vb, fs};
   endfunction

   // Expected bus for position (h,v) straight from the timing definitions.
   function automatic logic [31:0] model(input int h, v, hbs, hss, hst, vbs, vss, vst,
                                         input logic pol, fs);
      logic hs, vs;
      hs = (h >= hss && h < hss + hst) ? pol : ~pol;
      vs = (v >= vss && v < vss + vst) ? pol : ~pol;
      return pack(h, v, hs, vs, h >= hbs, v >= vbs, fs);
   endfunction

   typedef struct {
      int   cycles;
      logic en;
      int   h;
      int   v;
      logic hs, vs, hb, vb, fs;
   } vec_t;

   vec_t vecs[16];

   initial begin
      int   pulses;
      logic found;

      vecs[0]  = '{14, 1'b1, 14, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{2,  1'b1, 16, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{1,  1'b1, 17, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{2,  1'b1, 19, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{1,  1'b1, 0,  1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{11, 1'b1, 11, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{1,  1'b1, 12, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{1,  1'b0, 12, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{5,  1'b0, 12, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{8,  1'b1, 0,  2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{100,1'b1, 0,  7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[11] = '{20, 1'b1, 0,  8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[12] = '{19, 1'b1, 19, 8, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[13] = '{21, 1'b1, 0,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[14] = '{1,  1'b0, 0,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[15] = '{1,  1'b1, 1,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

      rst_n = 1'b0;
      en_d  = 1'b1;
      en_s  = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_d",   obs_d, pack(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      check("rst_rgb", 32'(bus_d.rgb), 32'd0);
      check("rst_p",   obs_p, pack(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
      check("rst_s",   obs_s, pack(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      check("rst_fc",  32'({fc_d, fc_s | fc_p}), 32'd0);

      // Default mode, both polarities, across two line wraps.
      rst_n = 1'b1;
      for (int t = 1; t <= 2 * 1056 + 10; t++) begin
         @(negedge clk);
         check("run_d", obs_d, model(t % 1056, t / 1056, 800, 840, 128, 600, 601, 4, 1'b1, 1'b0));
         check("run_p", obs_p, model(t % 1056, t / 1056, 800, 840, 128, 600, 601, 4, 1'b0, 1'b0));
      end

      // Asynchronous reset in mid-line, between clock edges.
      repeat (490) @(negedge clk);
      check("pre_rst_h", 32'(bus_d.hcount), 32'd500);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_d",   obs_d, pack(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      check("async_rst_p",   obs_p, pack(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
      check("async_rst_rgb", 32'(bus_d.rgb), 32'd0);
      repeat (3) @(negedge clk);

      // Small mode: three full frames from reset.
      rst_n  = 1'b1;
      pulses = 0;
      for (int t = 1; t <= 3 * S_HT * S_VT; t++) begin
         @(negedge clk);
         check("run_s", obs_s, model(t % S_HT, (t / S_HT) % S_VT, S_HBS, S_HSS, S_HST,
                                     S_VBS, S_VSS, S_VST, 1'b1, (t % (S_HT * S_VT)) == 0));
         if (fs_s) pulses++;
      end
      check("pulses", 32'(pulses), 32'd3);

      // Freeze at the double-wrap position.
      repeat (S_HT * S_VT - 1) @(negedge clk);
      check("pre_gate", obs_s, pack(19, 9, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
      en_s = 1'b0;
      for (int i = 0; i < 37; i++) begin
         @(negedge clk);
         check("gate_hold", obs_s, pack(19, 9, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
      end
      en_s = 1'b1;
      @(negedge clk);
      check("gate_resume", obs_s, pack(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));

      for (int i = 0; i < 16; i++) begin
         en_s = vecs[i].en;
         repeat (vecs[i].cycles) @(negedge clk);
         check($sformatf("vec%0d", i), obs_s,
               pack(vecs[i].h, vecs[i].v, vecs[i].hs, vecs[i].vs, vecs[i].hb, vecs[i].vb, vecs[i].fs));
      end
      en_s = 1'b1;

`ifdef VGA_TIMING_FRAME_CNT_EN
      force dut_s.frame_cnt_q = 16'hFFFE;
      #1 release dut_s.frame_cnt_q;
      for (int k = 0; k < 2; k++) begin
         found = 1'b0;
         for (int i = 0; i < 2 * S_HT * S_VT && !found; i++) begin
            @(negedge clk);
            if (fs_s) found = 1'b1;
         end
         check("fc_frame_seen", 32'(found), 32'd1);
         check($sformatf("fc_value%0d", k), 32'(fc_s), (k == 0) ? 32'h0000FFFF : 32'h00000000);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
